// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter: FSM encoding,
// default widths and the second-beat address step.
package mem_port_arbiter_pkg;

    localparam int DW_DEF    = 16;
    localparam int AW_DEF    = 20;
    localparam int BEAT2_INC = 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_D_BEAT2  = 2'd1,
        ST_D_RDWAIT = 2'd2
    } state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and the
// MEM stage; data accesses have priority, fetch uses the slot under a read return.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_valid,
    output logic [DW-1:0]   if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic            d_two,
    input  logic [AW-1:0]   d_addr,
    input  logic [2*DW-1:0] d_wdata,
    output logic            d_done,
    output logic [2*DW-1:0] d_rdata,
    output logic            stall_if,
    output logic            stall_mem,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    state_t          r_state;
    state_t          w_nxt;
    logic [DW-1:0]   r_lo;
    logic            r_rd_owner_if;

    logic            w_if_gnt;
    logic            w_d_done;
    logic            w_cap;
    logic            w_mem_en;
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_addr;
    logic [DW-1:0]   w_mem_wdata;
    logic [2*DW-1:0] w_d_rdata;
    logic [AW-1:0]   w_addr_b2;

    assign w_addr_b2 = d_addr + AW'(BEAT2_INC);

    always_comb begin
        w_nxt       = r_state;
        w_if_gnt    = 1'b0;
        w_d_done    = 1'b0;
        w_cap       = 1'b0;
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_d_rdata   = '0;
        case (r_state)
            ST_IDLE: begin
                if (d_req) begin
                    w_mem_en    = 1'b1;
                    w_mem_we    = d_we;
                    w_mem_addr  = d_addr;
                    w_mem_wdata = d_we ? d_wdata[DW-1:0] : '0;
                    if (d_two)
                        w_nxt = ST_D_BEAT2;
                    else if (d_we)
                        w_d_done = 1'b1;
                    else
                        w_nxt = ST_D_RDWAIT;
                end else if (if_req) begin
                    w_mem_en   = 1'b1;
                    w_mem_addr = if_addr;
                    w_if_gnt   = 1'b1;
                end
            end
            ST_D_BEAT2: begin
                w_mem_en    = 1'b1;
                w_mem_we    = d_we;
                w_mem_addr  = w_addr_b2;
                w_mem_wdata = d_we ? d_wdata[2*DW-1:DW] : '0;
                if (d_we) begin
                    w_d_done = 1'b1;
                    w_nxt    = ST_IDLE;
                end else begin
                    // beat-1 read data is on mem_rdata now
                    w_cap = 1'b1;
                    w_nxt = ST_D_RDWAIT;
                end
            end
            ST_D_RDWAIT: begin
                w_d_done  = 1'b1;
                w_d_rdata = d_two ? {mem_rdata, r_lo} : {{DW{1'b0}}, mem_rdata};
                // the port itself is idle while the last read beat returns
                if (if_req) begin
                    w_mem_en   = 1'b1;
                    w_mem_addr = if_addr;
                    w_if_gnt   = 1'b1;
                end
                w_nxt = ST_IDLE;
            end
            default: w_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_lo          <= '0;
            r_rd_owner_if <= 1'b0;
        end else begin
            r_state       <= w_nxt;
            r_rd_owner_if <= w_if_gnt;
            if (w_cap)
                r_lo <= mem_rdata;
        end
    end

    // outputs forced low for the whole reset window, not just after the edge
    assign if_gnt    = rst_n & w_if_gnt;
    assign d_done    = rst_n & w_d_done;
    assign mem_en    = rst_n & w_mem_en;
    assign mem_we    = rst_n & w_mem_we;
    assign mem_addr  = rst_n ? w_mem_addr  : '0;
    assign mem_wdata = rst_n ? w_mem_wdata : '0;
    assign d_rdata   = rst_n ? w_d_rdata   : '0;
    assign if_valid  = r_rd_owner_if;
    assign if_rdata  = rst_n ? mem_rdata : '0;

    assign stall_if  = if_req & ~if_gnt;
    assign stall_mem = d_req  & ~d_done;

endmodule
